// File: rtl/me_frame_loader.sv
// Frame loader: accepts a raster-ordered pixel stream and writes it into the
// template-block memory, then into the search-window memory. Addresses are
// column-major ({col,row}) to match the way the search engine reads them.
module me_frame_loader #(
  parameter int PIX_W  = 8,
  parameter int TB_DIM = 16,
  parameter int SW_DIM = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [PIX_W-1:0]              in_data,
  output logic                          in_ready,
  output logic                          tb_we,
  output logic [2*$clog2(TB_DIM)-1:0]   tb_addr,
  output logic [PIX_W-1:0]              tb_wdata,
  output logic                          sw_we,
  output logic [2*$clog2(SW_DIM)-1:0]   sw_addr,
  output logic [PIX_W-1:0]              sw_wdata,
  output logic                          busy,
  output logic                          done
);

  localparam int TB_LW = $clog2(TB_DIM);
  localparam int SW_LW = $clog2(SW_DIM);
  localparam int TB_AW = 2 * TB_LW;
  localparam int SW_AW = 2 * SW_LW;

  // Counters are sized for the larger window; the template phase uses the low bits.
  localparam logic [SW_LW-1:0] TB_MAX = SW_LW'(TB_DIM - 1);
  localparam logic [SW_LW-1:0] SW_MAX = SW_LW'(SW_DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_TB = 2'd1,
    S_LOAD_SW = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SW_LW-1:0] col_q, col_d;
  logic [SW_LW-1:0] row_q, row_d;

  logic             tb_we_q, tb_we_d;
  logic [TB_AW-1:0] tb_addr_q, tb_addr_d;
  logic [PIX_W-1:0] tb_wdata_q, tb_wdata_d;
  logic             sw_we_q, sw_we_d;
  logic [SW_AW-1:0] sw_addr_q, sw_addr_d;
  logic [PIX_W-1:0] sw_wdata_q, sw_wdata_d;
  logic             done_q, done_d;

  logic accept;
  logic tb_last;
  logic sw_last;

  assign accept  = in_valid && in_ready;
  assign tb_last = (col_q == TB_MAX) && (row_q == TB_MAX);
  assign sw_last = (col_q == SW_MAX) && (row_q == SW_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: abort wins; a start coinciding with the done pulse is dropped.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start && !done_q)     state_d = S_LOAD_TB;
        S_LOAD_TB: if (accept && tb_last)    state_d = S_LOAD_SW;
        S_LOAD_SW: if (accept && sw_last)    state_d = S_IDLE;
        default:                             state_d = S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs are decoded straight from the state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_LOAD_TB, S_LOAD_SW: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Raster counters and the one-cycle write stage for both memories.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    tb_we_d    = 1'b0;
    tb_addr_d  = tb_addr_q;
    tb_wdata_d = tb_wdata_q;
    sw_we_d    = 1'b0;
    sw_addr_d  = sw_addr_q;
    sw_wdata_d = sw_wdata_q;
    done_d     = 1'b0;
    if (clr) begin
      col_d      = '0;
      row_d      = '0;
      tb_addr_d  = '0;
      tb_wdata_d = '0;
      sw_addr_d  = '0;
      sw_wdata_d = '0;
    end else if (accept) begin
      if (state_q == S_LOAD_TB) begin
        tb_we_d    = 1'b1;
        tb_addr_d  = {col_q[TB_LW-1:0], row_q[TB_LW-1:0]};
        tb_wdata_d = in_data;
        // The last template pixel clears the counters for the window phase.
        if (tb_last) begin
          col_d = '0;
          row_d = '0;
        end else if (col_q == TB_MAX) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        sw_we_d    = 1'b1;
        sw_addr_d  = {col_q, row_q};
        sw_wdata_d = in_data;
        done_d     = sw_last;
        if (sw_last) begin
          col_d = '0;
          row_d = '0;
        end else if (col_q == SW_MAX) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  // Datapath registers; everything visible on the ports clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      tb_we_q    <= 1'b0;
      tb_addr_q  <= '0;
      tb_wdata_q <= '0;
      sw_we_q    <= 1'b0;
      sw_addr_q  <= '0;
      sw_wdata_q <= '0;
      done_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      tb_we_q    <= tb_we_d;
      tb_addr_q  <= tb_addr_d;
      tb_wdata_q <= tb_wdata_d;
      sw_we_q    <= sw_we_d;
      sw_addr_q  <= sw_addr_d;
      sw_wdata_q <= sw_wdata_d;
      done_q     <= done_d;
    end
  end

  assign tb_we    = tb_we_q;
  assign tb_addr  = tb_addr_q;
  assign tb_wdata = tb_wdata_q;
  assign sw_we    = sw_we_q;
  assign sw_addr  = sw_addr_q;
  assign sw_wdata = sw_wdata_q;
  assign done     = done_q;

endmodule
